// File: rtl/uarc_send_scheduler_if.sv
// Sender/interrupt bundle for the UARC send scheduler.
//   sends, datas, send_acks : per-bus 4-phase send handshake with remote senders
//   irq_valid, irq_bus, irq_addr, irq_data, irq_taken : interrupt offer to the core
// master = scheduler side, slave = sender/core side.
interface uarc_send_scheduler_if #(
   parameter int BUSES              = 8,
   parameter int BUS_IDX_WIDTH      = 3,
   parameter int PROGRAM_ADDR_WIDTH = 8,
   parameter int WORD_WIDTH         = 32
);
   logic [BUSES-1:0]                 sends;
   logic [BUSES-1:0][WORD_WIDTH-1:0] datas;
   logic [BUSES-1:0]                 send_acks;
   logic                             irq_valid;
   logic [BUS_IDX_WIDTH-1:0]         irq_bus;
   logic [PROGRAM_ADDR_WIDTH-1:0]    irq_addr;
   logic [WORD_WIDTH-1:0]            irq_data;
   logic                             irq_taken;

   modport master (
      input  sends, datas, irq_taken,
      output send_acks, irq_valid, irq_bus, irq_addr, irq_data
   );

   modport slave (
      output sends, datas, irq_taken,
      input  send_acks, irq_valid, irq_bus, irq_addr, irq_data
   );
endinterface

// File: rtl/uarc_send_scheduler.sv
// Round-robin scheduler that turns per-bus send requests into core interrupts.
// Picks one eligible bus, offers it to the core with its vector address and
// latched data, then completes a 4-phase ack with the sender once taken.
//   clk, reset         : clock, synchronous active-high reset
//   bus (master)       : sends/datas/send_acks and irq_* offer/accept signals
//   interrupt_enables  : per-bus enable mask (normal mode)
//   bus_selections     : per-bus selection mask (wait mode)
//   wait_mode          : core is executing a wait instruction
//   vector_we/index/addr : vector table write port
//   busy               : scheduler is not idle
module uarc_send_scheduler #(
   parameter int BUSES              = 8,
   parameter int BUS_IDX_WIDTH      = 3,
   parameter int PROGRAM_ADDR_WIDTH = 8,
   parameter int WORD_WIDTH         = 32
) (
   input  logic                          clk,
   input  logic                          reset,
   uarc_send_scheduler_if.master         bus,
   input  logic [BUSES-1:0]              interrupt_enables,
   input  logic [BUSES-1:0]              bus_selections,
   input  logic                          wait_mode,
   input  logic                          vector_we,
   input  logic [BUS_IDX_WIDTH-1:0]      vector_index,
   input  logic [PROGRAM_ADDR_WIDTH-1:0] vector_addr,
   output logic                          busy
);

   typedef enum logic [1:0] {IDLE, OFFER, ACK} state_t;

   // rr_ptr starts at the last bus so the first scan begins at bus 0
   localparam logic [BUS_IDX_WIDTH-1:0] RR_INIT   = BUS_IDX_WIDTH'(BUSES - 1);
   localparam logic [BUS_IDX_WIDTH:0]   BUSES_LIM = (BUS_IDX_WIDTH + 1)'(BUSES);

   state_t                        state, state_nxt;
   logic [BUS_IDX_WIDTH-1:0]      rr_ptr, grant, pick;
   logic                          found;
   logic [BUSES-1:0]              eligible;
   logic                          granted_send;
   logic [PROGRAM_ADDR_WIDTH-1:0] vec [BUSES];
   logic [PROGRAM_ADDR_WIDTH-1:0] addr_q;
   logic [WORD_WIDTH-1:0]         data_q;

   assign eligible     = wait_mode ? (bus.sends & bus_selections)
                                   : (bus.sends & interrupt_enables);
   assign granted_send = bus.sends[grant];

   // first eligible bus scanning upward from rr_ptr+1, wrapping at BUSES
   always_comb begin : pick_scan
      logic [31:0] j;
      pick  = '0;
      found = 1'b0;
      j     = '0;
      for (int i = 0; i < BUSES; i++) begin
         j = (32'(rr_ptr) + 32'(i) + 32'd1) % 32'(BUSES);
         if (!found && eligible[j[BUS_IDX_WIDTH-1:0]]) begin
            found = 1'b1;
            pick  = j[BUS_IDX_WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // irq_taken is checked before withdrawal so a simultaneous take still acks
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (found) state_nxt = OFFER;
         OFFER:   if (bus.irq_taken)      state_nxt = ACK;
                  else if (!granted_send) state_nxt = IDLE;
         ACK:     if (!granted_send) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // grant, vector and data are captured once at selection; later mask or
   // table changes cannot disturb an in-flight grant
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr <= RR_INIT;
         grant  <= '0;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         if (state == IDLE && found) begin
            grant  <= pick;
            addr_q <= vec[pick];
            data_q <= bus.datas[pick];
         end
         if (state == OFFER && bus.irq_taken) rr_ptr <= grant;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < BUSES; i++) vec[i] <= '0;
      end else if (vector_we && ({1'b0, vector_index} < BUSES_LIM)) begin
         vec[vector_index] <= vector_addr;
      end
   end

   // outputs are fully decoded from state so at most one ack bit is ever set
   assign bus.irq_valid = (state == OFFER);
   assign bus.irq_bus   = (state == OFFER) ? grant  : '0;
   assign bus.irq_addr  = (state == OFFER) ? addr_q : '0;
   assign bus.irq_data  = (state == OFFER) ? data_q : '0;
   assign bus.send_acks = (state == ACK) ? (BUSES'(1) << grant) : '0;
   assign busy          = (state != IDLE);

endmodule

// File: tb/tb_uarc_send_scheduler.sv
// Self-checking bench for uarc_send_scheduler: directed scenarios followed by
// randomized traffic checked against a round-robin reference model.
module tb_uarc_send_scheduler;
   localparam int B  = 8;
   localparam int IW = 3;
   localparam int AW = 8;
   localparam int WW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic [B-1:0]  interrupt_enables, bus_selections;
   logic          wait_mode, vector_we;
   logic [IW-1:0] vector_index;
   logic [AW-1:0] vector_addr;
   logic          busy;

   always #5 clk = ~clk;

   uarc_send_scheduler_if #(.BUSES(B), .BUS_IDX_WIDTH(IW),
                            .PROGRAM_ADDR_WIDTH(AW), .WORD_WIDTH(WW)) bus ();

   uarc_send_scheduler #(.BUSES(B), .BUS_IDX_WIDTH(IW),
                         .PROGRAM_ADDR_WIDTH(AW), .WORD_WIDTH(WW)) dut (
      .clk               (clk),
      .reset             (reset),
      .bus               (bus),
      .interrupt_enables (interrupt_enables),
      .bus_selections    (bus_selections),
      .wait_mode         (wait_mode),
      .vector_we         (vector_we),
      .vector_index      (vector_index),
      .vector_addr       (vector_addr),
      .busy              (busy)
   );

   // reference model
   int            m_ptr;
   logic [AW-1:0] m_vec [B];
   logic [AW-1:0] m_lat_addr;
   logic [WW-1:0] m_lat_data;
   logic [B-1:0][WW-1:0] d;
   int            npass = 0;
   int            ntot  = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [B-1:0] oh(input int b);
      logic [B-1:0] r;
      r    = '0;
      r[b] = 1'b1;
      return r;
   endfunction

   function automatic logic [B-1:0] elig();
      return wait_mode ? (bus.sends & bus_selections) : (bus.sends & interrupt_enables);
   endfunction

   function automatic int ref_pick(input logic [B-1:0] m, input int ptr);
      for (int k = 1; k <= B; k++)
         if (m[(ptr + k) % B]) return (ptr + k) % B;
      return -1;
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      bus.sends = '0; bus.irq_taken = 1'b0;
      interrupt_enables = '0; bus_selections = '0; wait_mode = 1'b0;
      vector_we = 1'b0; vector_index = '0; vector_addr = '0;
      for (int i = 0; i < B; i++) d[i] = $urandom;
      bus.datas = d;
      tick(); tick();
      reset = 1'b0;
      m_ptr = B - 1;
      for (int i = 0; i < B; i++) m_vec[i] = '0;
   endtask

   task automatic check_offer(input string tag, input int b);
      m_lat_addr = m_vec[b];
      m_lat_data = d[b];
      chk({tag, "_valid"}, bus.irq_valid, 1);
      chk({tag, "_bus"},   bus.irq_bus, b);
      chk({tag, "_addr"},  bus.irq_addr, m_lat_addr);
      chk({tag, "_data"},  bus.irq_data, m_lat_data);
      chk({tag, "_busy"},  busy, 1);
      chk({tag, "_noack"}, bus.send_acks, 0);
   endtask

   // take the offer, hold the ack for 'hold' cycles, then release the sender
   task automatic take_and_finish(input string tag, input int b, input int hold);
      bus.irq_taken = 1'b1;
      tick();
      bus.irq_taken = 1'b0;
      m_ptr = b;
      chk({tag, "_ack"}, bus.send_acks, oh(b));
      chk({tag, "_ack_novalid"}, bus.irq_valid, 0);
      for (int i = 0; i < hold; i++) begin
         tick();
         chk({tag, "_ack_hold"}, bus.send_acks, oh(b));
      end
      bus.sends = '0;
      #1;
      chk({tag, "_ack_before_edge"}, bus.send_acks, oh(b));
      tick();
      chk({tag, "_ack_drop"}, bus.send_acks, 0);
      chk({tag, "_idle"}, busy, 0);
   endtask

   initial begin
      int b;
      logic [B-1:0] m;

      // reset state
      do_reset();
      chk("rst_acks",  bus.send_acks, 0);
      chk("rst_valid", bus.irq_valid, 0);
      chk("rst_bus",   bus.irq_bus, 0);
      chk("rst_addr",  bus.irq_addr, 0);
      chk("rst_data",  bus.irq_data, 0);
      chk("rst_busy",  busy, 0);

      // two requesters: bus 0 first, then bus 2
      interrupt_enables = '1;
      bus.sends = 8'b0000_0101;
      tick();
      b = ref_pick(elig(), m_ptr);
      check_offer("rr_first", b);
      bus.irq_taken = 1'b1;
      tick();
      bus.irq_taken = 1'b0;
      m_ptr = b;
      chk("rr_first_ack", bus.send_acks, oh(b));
      bus.sends[b] = 1'b0;
      tick();
      chk("rr_first_drop", bus.send_acks, 0);
      tick();
      b = ref_pick(elig(), m_ptr);
      check_offer("rr_second", b);
      take_and_finish("rr_second", b, 1);

      // vector address and data, table write during offer must not disturb it
      vector_we = 1'b1; vector_index = 3'd3; vector_addr = 8'h40;
      tick();
      m_vec[3] = 8'h40;
      vector_we = 1'b0;
      d[3] = 32'hDEADBEEF; bus.datas = d;
      bus.sends = 8'b0000_1000;
      tick();
      b = ref_pick(elig(), m_ptr);
      check_offer("vec", b);
      vector_we = 1'b1; vector_index = 3'd3; vector_addr = 8'h77;
      tick();
      m_vec[3] = 8'h77;
      vector_we = 1'b0;
      chk("vec_addr_hold", bus.irq_addr, m_lat_addr);
      chk("vec_still_valid", bus.irq_valid, 1);
      take_and_finish("vec", b, 2);

      // wait mode uses bus_selections, normal mode uses interrupt_enables
      wait_mode = 1'b1; bus_selections = 8'b0000_0010; interrupt_enables = 8'b0000_0001;
      bus.sends = 8'b0000_0011;
      tick();
      b = ref_pick(elig(), m_ptr);
      check_offer("wait", b);
      take_and_finish("wait", b, 0);
      wait_mode = 1'b0;
      bus.sends = 8'b0000_0011;
      tick();
      b = ref_pick(elig(), m_ptr);
      check_offer("nowait", b);
      take_and_finish("nowait", b, 0);

      // withdrawal before take: no ack, pointer unchanged
      interrupt_enables = '1;
      bus.sends = oh(5);
      tick();
      check_offer("wd", 5);
      bus.sends = '0;
      tick();
      chk("wd_noack", bus.send_acks, 0);
      chk("wd_novalid", bus.irq_valid, 0);
      chk("wd_idle", busy, 0);
      bus.sends = '1;
      tick();
      b = ref_pick(elig(), m_ptr);
      check_offer("wd_ptr", b);
      take_and_finish("wd_ptr", b, 0);

      // take and withdrawal in the same cycle: take wins
      bus.sends = oh(6);
      tick();
      check_offer("race", 6);
      bus.sends = '0; bus.irq_taken = 1'b1;
      tick();
      bus.irq_taken = 1'b0;
      m_ptr = 6;
      chk("race_ack", bus.send_acks, oh(6));
      tick();
      chk("race_drop", bus.send_acks, 0);
      chk("race_idle", busy, 0);

      // fairness with everyone requesting
      do_reset();
      interrupt_enables = '1;
      bus.sends = '1;
      for (int n = 0; n <= B; n++) begin
         tick();
         b = ref_pick(elig(), m_ptr);
         check_offer("fair", b);
         bus.irq_taken = 1'b1;
         tick();
         bus.irq_taken = 1'b0;
         m_ptr = b;
         chk("fair_ack", bus.send_acks, oh(b));
         bus.sends[b] = 1'b0;
         tick();
         chk("fair_drop", bus.send_acks, 0);
         bus.sends[b] = 1'b1;
      end
      bus.sends = '0;
      tick();

      // reset during ack aborts the grant
      do_reset();
      interrupt_enables = '1;
      bus.sends = oh(4);
      tick();
      check_offer("rstack", 4);
      bus.irq_taken = 1'b1;
      tick();
      bus.irq_taken = 1'b0;
      chk("rstack_ack", bus.send_acks, oh(4));
      reset = 1'b1;
      tick();
      chk("rstack_noack", bus.send_acks, 0);
      chk("rstack_novalid", bus.irq_valid, 0);
      chk("rstack_idle", busy, 0);
      bus.sends = '0;
      reset = 1'b0;
      m_ptr = B - 1;
      for (int i = 0; i < B; i++) m_vec[i] = '0;
      tick();

      // randomized traffic
      for (int it = 0; it < 300; it++) begin
         bus.sends = '0;
         if ($urandom_range(0, 2) == 0) begin
            vector_we = 1'b1; vector_index = IW'($urandom); vector_addr = AW'($urandom);
         end
         tick();
         if (vector_we) m_vec[vector_index] = vector_addr;
         vector_we = 1'b0;
         for (int i = 0; i < B; i++) d[i] = $urandom;
         bus.datas = d;
         bus.sends = B'($urandom);
         interrupt_enables = B'($urandom);
         bus_selections = B'($urandom);
         wait_mode = 1'($urandom);
         m = elig();
         tick();
         if (m == '0) begin
            chk("rnd_idle_busy", busy, 0);
            chk("rnd_idle_valid", bus.irq_valid, 0);
         end else begin
            b = ref_pick(m, m_ptr);
            check_offer("rnd", b);
            // masks, mode and data may move freely once a grant is in flight
            interrupt_enables = B'($urandom);
            bus_selections = B'($urandom);
            wait_mode = 1'($urandom);
            for (int i = 0; i < B; i++) d[i] = $urandom;
            bus.datas = d;
            case ($urandom_range(0, 2))
               0: begin
                  bus.sends[b] = 1'b0;
                  tick();
                  chk("rnd_wd_noack", bus.send_acks, 0);
                  chk("rnd_wd_idle", busy, 0);
               end
               1: take_and_finish("rnd", b, $urandom_range(0, 3));
               default: begin
                  tick();
                  chk("rnd_hold_bus", bus.irq_bus, b);
                  chk("rnd_hold_data", bus.irq_data, m_lat_data);
                  take_and_finish("rnd_late", b, 1);
               end
            endcase
         end
      end

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
